luma_hist_engine: RTL and testbench

Per-frame luma histogram stage. It consumes the polarity-normalized grayscale stream leaving the RGB-to-Y stage, in parallel with the gray line buffer. It accumulates a 2^BIN_BITS-bin histogram over exactly one frame per request. Bins are returned one per four-phase strobe/ack exchange with the AXI register bridge.

---
 rtl/luma_hist_pkg.sv | 33 +++
 rtl/strobe_sync.sv | 38 +++
 rtl/luma_hist_engine.sv | 205 ++++++++++++++++++++
 tb/tb_luma_hist_engine.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/luma_hist_pkg.sv
// luma_hist_pkg: shared definitions for the luma histogram engine.
// State encoding, bin-count derivation and pipeline drain length.
package luma_hist_pkg;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLEAR   = 3'd1;
  localparam logic [2:0] S_WAIT_VS = 3'd2;
  localparam logic [2:0] S_WAIT_DV = 3'd3;
  localparam logic [2:0] S_COUNT   = 3'd4;
  localparam logic [2:0] S_DRAIN   = 3'd5;
  localparam logic [2:0] S_ACK     = 3'd6;
  localparam logic [2:0] S_NEXT    = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE    = S_IDLE,
    ST_CLEAR   = S_CLEAR,
    ST_WAIT_VS = S_WAIT_VS,
    ST_WAIT_DV = S_WAIT_DV,
    ST_COUNT   = S_COUNT,
    ST_DRAIN   = S_DRAIN,
    ST_ACK     = S_ACK,
    ST_NEXT    = S_NEXT
  } state_e;

  // Cycles the increment pipeline needs to flush after the closing vsync.
  localparam int DRAIN_CYCLES = 2;

  // Number of histogram bins for a given index width.
  function automatic int nbins(input int bin_bits);
    return 1 << bin_bits;
  endfunction

endpackage

// File: rtl/strobe_sync.sv
// strobe_sync: brings an asynchronous level strobe into the clk domain
// through two flops and produces registered single-cycle rise/fall pulses.
// Generic enough to serve the write-strobe path as well.
module strobe_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic strobe_i,
  output logic rise_o,
  output logic fall_o
);

  logic r_meta;
  logic r_sync;
  logic r_sync_q;
  logic r_rise;
  logic r_fall;

  // Two-flop synchronizer, delayed copy, and registered edge pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_sync_q <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
    end else begin
      r_meta   <= strobe_i;
      r_sync   <= r_meta;
      r_sync_q <= r_sync;
      r_rise   <= r_sync & ~r_sync_q;
      r_fall   <= ~r_sync & r_sync_q;
    end
  end

  assign rise_o = r_rise;
  assign fall_o = r_fall;

endmodule

// File: rtl/luma_hist_engine.sv
// luma_hist_engine: one-frame luma histogram per read request, bins returned
// one per four-phase strobe/ack exchange.
// Build option: LUMA_HIST_SAT_EN -- when defined, bin counters saturate at
// all-ones; otherwise they wrap.
module luma_hist_engine
  import luma_hist_pkg::*;
#(
  parameter int BIN_BITS = 3,
  parameter int COUNT_W  = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  luma_i,
  input  logic        dv_i,
  input  logic        vs_i,
  input  logic        rd_strobe_i,
  output logic        rd_ack_o,
  output logic [31:0] bin_o,
  output logic        busy_o
);

  localparam int NBINS = nbins(BIN_BITS);
  localparam logic [BIN_BITS-1:0] LAST_BIN = '1;

  state_e                r_state, w_state_next;
  logic [BIN_BITS-1:0]   r_addr, w_addr_next;
  logic                  r_ack, w_ack_next;
  logic [31:0]           r_bin, w_bin_next;
  logic                  r_last, w_last_next;
  logic [1:0]            r_drain, w_drain_next;

  logic                  w_rise, w_fall;
  logic                  r_vs_q;
  logic                  w_vs_rise;

  logic                  w_accept;
  logic                  r_s1_dv;
  logic [BIN_BITS-1:0]   r_s1_idx;
  logic                  r_s2_dv;
  logic [BIN_BITS-1:0]   r_s2_idx;
  logic [COUNT_W-1:0]    r_s2_cnt;

  logic [COUNT_W-1:0]    r_bins [NBINS];
  logic                  w_we;
  logic [BIN_BITS-1:0]   w_waddr, w_raddr;
  logic [COUNT_W-1:0]    w_wdata, w_rdata;

  // Low luma bits never select a bin.
  logic w_unused;
  assign w_unused = ^luma_i[7-BIN_BITS:0];

  function automatic logic [COUNT_W-1:0] bump(input logic [COUNT_W-1:0] v);
`ifdef LUMA_HIST_SAT_EN
    return (&v) ? v : v + 1'b1;
`else
    return v + 1'b1;
`endif
  endfunction

  strobe_sync u_rd_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .strobe_i (rd_strobe_i),
    .rise_o   (w_rise),
    .fall_o   (w_fall)
  );

  assign w_vs_rise = vs_i & ~r_vs_q;
  // The first pixel in WAIT_DV is counted; a vsync rise there ends an empty frame.
  assign w_accept  = dv_i & ((r_state == ST_COUNT) |
                             ((r_state == ST_WAIT_DV) & ~w_vs_rise));

  // Single write port: zeroing during CLEAR, otherwise the S3 increment.
  assign w_we    = (r_state == ST_CLEAR) | r_s2_dv;
  assign w_waddr = (r_state == ST_CLEAR) ? r_addr : r_s2_idx;
  assign w_wdata = (r_state == ST_CLEAR) ? '0 : bump(r_s2_cnt);

  // Single read port, shared by the pipeline and the readout; a write landing
  // on the same edge is forwarded so back-to-back hits and the final pixel
  // before readout are never lost.
  assign w_raddr = r_s1_dv ? r_s1_idx : r_addr;
  assign w_rdata = (w_we && (w_waddr == w_raddr)) ? w_wdata : r_bins[w_raddr];

  // Bin storage write port (contents deliberately not reset).
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_bins[w_waddr] <= w_wdata;
    end
  end

  // Vsync edge history and the S1/S2 stages of the increment pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_q   <= 1'b0;
      r_s1_dv  <= 1'b0;
      r_s1_idx <= '0;
      r_s2_dv  <= 1'b0;
      r_s2_idx <= '0;
      r_s2_cnt <= '0;
    end else begin
      r_vs_q   <= vs_i;
      r_s1_dv  <= w_accept;
      r_s1_idx <= luma_i[7 -: BIN_BITS];
      r_s2_dv  <= r_s1_dv;
      r_s2_idx <= r_s1_idx;
      r_s2_cnt <= w_rdata;
    end
  end

  // FSM state and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_ack   <= 1'b0;
      r_bin   <= '0;
      r_last  <= 1'b0;
      r_drain <= '0;
    end else begin
      r_state <= w_state_next;
      r_addr  <= w_addr_next;
      r_ack   <= w_ack_next;
      r_bin   <= w_bin_next;
      r_last  <= w_last_next;
      r_drain <= w_drain_next;
    end
  end

  // Next-state and output decode; strobe edges outside IDLE/ACK/NEXT are ignored.
  always_comb begin
    w_state_next = r_state;
    w_addr_next  = r_addr;
    w_ack_next   = r_ack;
    w_bin_next   = r_bin;
    w_last_next  = r_last;
    w_drain_next = r_drain;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_state_next = ST_CLEAR;
          w_addr_next  = '0;
        end
      end
      ST_CLEAR: begin
        if (r_addr == LAST_BIN) begin
          w_state_next = ST_WAIT_VS;
          w_addr_next  = '0;
        end else begin
          w_addr_next = r_addr + 1'b1;
        end
      end
      ST_WAIT_VS: begin
        if (vs_i) begin
          w_state_next = ST_WAIT_DV;
        end
      end
      ST_WAIT_DV: begin
        if (w_vs_rise) begin
          w_state_next = ST_DRAIN;
          w_drain_next = '0;
        end else if (dv_i) begin
          w_state_next = ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (w_vs_rise) begin
          w_state_next = ST_DRAIN;
          w_drain_next = '0;
        end
      end
      ST_DRAIN: begin
        if (r_drain == 2'(DRAIN_CYCLES - 1)) begin
          w_bin_next   = 32'(w_rdata);
          w_ack_next   = 1'b1;
          w_last_next  = (r_addr == LAST_BIN);
          w_addr_next  = r_addr + 1'b1;
          w_state_next = ST_ACK;
        end else begin
          w_drain_next = r_drain + 1'b1;
        end
      end
      ST_ACK: begin
        if (w_fall) begin
          w_ack_next   = 1'b0;
          w_state_next = r_last ? ST_IDLE : ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (w_rise) begin
          w_bin_next   = 32'(w_rdata);
          w_ack_next   = 1'b1;
          w_last_next  = (r_addr == LAST_BIN);
          w_addr_next  = r_addr + 1'b1;
          w_state_next = ST_ACK;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign rd_ack_o = r_ack;
  assign bin_o    = r_bin;
  assign busy_o   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_luma_hist_engine.sv
// tb_luma_hist_engine: directed vector table plus randomized frames checked
// against a bin-count model. A second instance with 4-bit counters runs in
// lockstep to cover counter overflow (wrap, or saturate with LUMA_HIST_SAT_EN).
module tb_luma_hist_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [7:0]  luma_i;
  logic        dv_i, vs_i, rd_strobe_i;
  logic        ack32, busy32, ack4, busy4;
  logic [31:0] bin32, bin4;

  luma_hist_engine #(.BIN_BITS(3), .COUNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .luma_i(luma_i), .dv_i(dv_i), .vs_i(vs_i),
    .rd_strobe_i(rd_strobe_i), .rd_ack_o(ack32), .bin_o(bin32), .busy_o(busy32)
  );

  luma_hist_engine #(.BIN_BITS(3), .COUNT_W(4)) dut_w4 (
    .clk(clk), .rst_n(rst_n), .luma_i(luma_i), .dv_i(dv_i), .vs_i(vs_i),
    .rd_strobe_i(rd_strobe_i), .rd_ack_o(ack4), .bin_o(bin4), .busy_o(busy4)
  );

  typedef struct packed {
    logic [1:0]        mode;   // 0: constant luma, 1: ramp (i*32) mod 256
    logic [15:0]       npix;
    logic [7:0]        luma;
    logic              gaps;   // random dv=0 gaps between pixels
    logic [7:0][15:0]  exp;    // expected bin counts, exp[7] first
  } vec_t;

  vec_t        vecs[6];
  int          n_tests = 0;
  int          n_fail  = 0;
  byte unsigned pix_q[$];
  int          exp_cnt[8];

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint narrow4(input int c);
`ifdef LUMA_HIST_SAT_EN
    return (c > 15) ? 15 : c;
`else
    return c % 16;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic vs_pulse();
    vs_i = 1'b1; dv_i = 1'b0;
    tick(); tick();
    vs_i = 1'b0;
    tick(); tick();
  endtask

  // Counts clock edges until ack reaches lvl; -1 on timeout.
  task automatic wait_ack(input logic lvl, input int limit, output int n);
    bit done;
    done = 1'b0;
    n = 0;
    while (!done && n < limit) begin
      tick();
      n++;
      if (ack32 === lvl) done = 1'b1;
    end
    if (!done) n = -1;
  endtask

  task automatic check_bin(input int b);
    check($sformatf("bin%0d_w32", b), bin32, exp_cnt[b]);
    check($sformatf("bin%0d_w4", b), bin4, narrow4(exp_cnt[b]));
  endtask

  // Model: each pixel lands in the bin given by its top three luma bits.
  task automatic model_from_queue();
    foreach (exp_cnt[b]) exp_cnt[b] = 0;
    foreach (pix_q[i]) exp_cnt[int'(pix_q[i]) / 32]++;
  endtask

  // Full request: frame capture of pix_q, then all eight bins read back.
  task automatic run_frame(input bit gaps);
    int n;
    rd_strobe_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      dv_i   = (i < 16) ? 1'($urandom_range(0, 1)) : 1'b0;
      luma_i = 8'($urandom);
      tick();
    end
    check("busy_in_frame", busy32, 1);
    vs_pulse();
    foreach (pix_q[i]) begin
      if (gaps) begin
        int g = $urandom_range(0, 2);
        repeat (g) begin
          dv_i = 1'b0; luma_i = 8'($urandom); tick();
        end
      end
      dv_i = 1'b1; luma_i = pix_q[i]; tick();
    end
    dv_i = 1'b0;
    tick(); tick();
    vs_i = 1'b1;
    tick(); tick();
    vs_i = 1'b0;
    wait_ack(1'b1, 40, n);
    check("ack_bin0_seen", (n > 0), 1);
    check_bin(0);
    rd_strobe_i = 1'b0;
    wait_ack(1'b0, 40, n);
    check("ack_fall_latency", n, 4);
    for (int b = 1; b < 8; b++) begin
      // A later frame arriving mid-readout must not disturb the counts.
      vs_pulse();
      for (int k = 0; k < 5; k++) begin
        dv_i = 1'b1; luma_i = 8'($urandom); tick();
      end
      dv_i = 1'b0;
      rd_strobe_i = 1'b1;
      wait_ack(1'b1, 40, n);
      check("ack_rise_latency", n, 4);
      check_bin(b);
      rd_strobe_i = 1'b0;
      wait_ack(1'b0, 40, n);
      check("ack_fall_latency", n, 4);
    end
    check("busy_done_w32", busy32, 0);
    check("busy_done_w4", busy4, 0);
    $display("[TB] frame %0d px: bins %0d %0d %0d %0d %0d %0d %0d %0d",
             pix_q.size(), exp_cnt[0], exp_cnt[1], exp_cnt[2], exp_cnt[3],
             exp_cnt[4], exp_cnt[5], exp_cnt[6], exp_cnt[7]);
  endtask

  task automatic run_vec(input int v);
    pix_q.delete();
    for (int i = 0; i < int'(vecs[v].npix); i++) begin
      if (vecs[v].mode == 2'd1) pix_q.push_back(8'((i * 32) % 256));
      else                      pix_q.push_back(vecs[v].luma);
    end
    for (int b = 0; b < 8; b++) exp_cnt[b] = int'(vecs[v].exp[b]);
    run_frame(vecs[v].gaps);
  endtask

  initial begin
    vecs[0] = '{mode: 2'd1, npix: 16'd64, luma: 8'h00, gaps: 1'b1, exp: {8{16'd8}}};
    vecs[1] = '{mode: 2'd0, npix: 16'd64, luma: 8'hFF, gaps: 1'b0, exp: {16'd64, {7{16'd0}}}};
    vecs[2] = '{mode: 2'd0, npix: 16'd0,  luma: 8'h00, gaps: 1'b0, exp: {8{16'd0}}};
    vecs[3] = '{mode: 2'd0, npix: 16'd37, luma: 8'h10, gaps: 1'b1, exp: {{7{16'd0}}, 16'd37}};
    vecs[4] = '{mode: 2'd0, npix: 16'd20, luma: 8'h00, gaps: 1'b0, exp: {{7{16'd0}}, 16'd20}};
    vecs[5] = '{mode: 2'd0, npix: 16'd10, luma: 8'h80, gaps: 1'b1, exp: {{3{16'd0}}, 16'd10, {4{16'd0}}}};

    rst_n = 1'b0; luma_i = '0; dv_i = 1'b0; vs_i = 1'b0; rd_strobe_i = 1'b0;
    tick(); tick(); tick();
    check("reset_ack", ack32, 0);
    check("reset_bin", bin32, 0);
    check("reset_busy", busy32, 0);
    check("reset_busy_w4", busy4, 0);
    rst_n = 1'b1;
    tick(); tick();

    for (int v = 0; v < 5; v++) run_vec(v);

    // Randomized frames, with runs of repeated luma to stress forwarding.
    for (int f = 0; f < 6; f++) begin
      int npix = $urandom_range(0, 120);
      byte unsigned last = 8'($urandom);
      pix_q.delete();
      for (int i = 0; i < npix; i++) begin
        if ($urandom_range(0, 2) != 0) last = 8'($urandom);
        pix_q.push_back(last);
      end
      model_from_queue();
      run_frame(1'($urandom_range(0, 1)));
    end

    // Asynchronous reset while counting aborts the request.
    rd_strobe_i = 1'b1;
    repeat (20) tick();
    vs_pulse();
    for (int k = 0; k < 5; k++) begin
      dv_i = 1'b1; luma_i = 8'($urandom); tick();
    end
    check("busy_counting", busy32, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", busy32, 0);
    check("abort_busy_w4", busy4, 0);
    check("abort_ack", ack32, 0);
    rd_strobe_i = 1'b0; dv_i = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    check("after_abort_busy", busy32, 0);
    $display("[TB] reset during COUNT applied");
    run_vec(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
